// File: rtl/des_key_schedule_if.sv
// Handshake and data bundle between the DES key-schedule generator and its consumer.
// The master drives the start/advance controls. The slave returns the round keys and status.
interface des_key_schedule_if;
    logic        start;
    logic [1:64] key;
    logic        decrypt;
    logic        advance;
    logic [1:48] subkey;
    logic        subkey_valid;
    logic [3:0]  round;
    logic        busy;
    logic        done;
    logic        parity_err;

    modport master (
        output start, key, decrypt, advance,
        input  subkey, subkey_valid, round, busy, done, parity_err
    );

    modport slave (
        input  start, key, decrypt, advance,
        output subkey, subkey_valid, round, busy, done, parity_err
    );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: delivers K1..K16 (or K16..K1) one subkey per advance.
// Optional key odd-parity check is compiled in with `define KEY_PARITY_CHECK_EN.
module des_key_schedule (
    input  logic              clk,
    input  logic              rst,
    des_key_schedule_if.slave ks
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam int unsigned pc1_tab [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int unsigned pc2_tab [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Bit k is set where the DES shift schedule moves by one position instead of two.
    localparam logic [1:16] single_shift = 16'b1100_0000_1000_0001;

    state_t      state_q, state_d;
    logic [1:28] c_q, d_q, c_d, d_d;
    logic        dir_q, dir_d;
    logic [1:48] subkey_q;
    logic        subkey_load;
    logic [3:0]  round_q, round_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:56] cd0, cd_d;
    logic [1:48] pc2_d;
    logic [4:0]  shift_idx;
    logic        shift_two;
    logic        accept;

    function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
        return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
        return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

    for (genvar g = 1; g <= 56; g++) begin : g_pc1
        assign cd0[g] = ks.key[pc1_tab[g]];
    end

    assign cd_d = {c_d, d_d};
    for (genvar g = 1; g <= 48; g++) begin : g_pc2
        assign pc2_d[g] = cd_d[pc2_tab[g]];
    end

    assign accept = (state_q == IDLE) && ks.start;

    // Encrypt steps forward to K(round+2). Decrypt undoes the shift that produced K(16-round).
    assign shift_idx = dir_q ? (5'd16 - {1'b0, round_q}) : ({1'b0, round_q} + 5'd2);
    assign shift_two = !single_shift[shift_idx];

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        d_d         = d_q;
        dir_d       = dir_q;
        round_d     = round_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        subkey_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dir_d       = ks.decrypt;
                    // Decrypt starts from C0,D0 directly: sixteen shifts total 28, so C16 == C0.
                    c_d         = ks.decrypt ? cd0[1:28]  : rotl(cd0[1:28], 1'b0);
                    d_d         = ks.decrypt ? cd0[29:56] : rotl(cd0[29:56], 1'b0);
                    subkey_load = 1'b1;
                    round_d     = 4'd0;
                    valid_d     = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (valid_q && ks.advance) begin
                    if (round_q == 4'd15) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        round_d = 4'd0;
                        state_d = IDLE;
                    end else begin
                        round_d     = round_q + 4'd1;
                        c_d         = dir_q ? rotr(c_q, shift_two) : rotl(c_q, shift_two);
                        d_d         = dir_q ? rotr(d_q, shift_two) : rotl(d_q, shift_two);
                        subkey_load = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            c_q      <= '0;
            d_q      <= '0;
            dir_q    <= 1'b0;
            subkey_q <= '0;
            round_q  <= 4'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dir_q   <= dir_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (subkey_load) subkey_q <= pc2_d;
        end
    end

    assign ks.subkey       = subkey_q;
    assign ks.subkey_valid = valid_q;
    assign ks.round        = round_q;
    assign ks.busy         = busy_q;
    assign ks.done         = done_q;

`ifdef KEY_PARITY_CHECK_EN
    logic [0:7] byte_even;
    logic       parity_q;

    // DES key bytes must carry odd parity; an even byte flags the key.
    for (genvar b = 0; b < 8; b++) begin : g_par
        assign byte_even[b] = ~^ks.key[8*b+1 +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         parity_q <= 1'b0;
        else if (accept) parity_q <= |byte_even;
    end

    assign ks.parity_err = parity_q;
`else
    assign ks.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: random keys against a table-driven DES key model.
// The model works on plain 64-bit integers and applies cumulative left shifts.
module tb_des_key_schedule;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    des_key_schedule_if ks_if ();
    des_key_schedule dut (.clk(clk), .rst(rst), .ks(ks_if));

    int checks = 0;
    int errors = 0;

`ifdef KEY_PARITY_CHECK_EN
    localparam bit par_en = 1'b1;
`else
    localparam bit par_en = 1'b0;
`endif

    localparam logic [63:0] kat_key = 64'h133457799BBCDFF1;
    localparam logic [47:0] kat_k1  = 48'h1B02EFFC7072;
    localparam logic [47:0] kat_k2  = 48'h79AED9DBC9E5;
    localparam logic [47:0] kat_k16 = 48'hCB3D8B0E17F5;

    int pc1_t [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                       10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                       63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                       14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    int pc2_t [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                       23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                       41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                       44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [47:0] exp_keys [16];  // exp_keys[i] is K(i+1)
    logic        exp_par;
    logic [47:0] obs_first, obs_second, obs_last;

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int s);
        logic [55:0] t;
        t = {x, x} << s;
        return t[55:28];
    endfunction

    // Bit n of a FIPS bus (1 = MSB) lives at index width-n of a packed [width-1:0] value.
    task automatic build_model(input logic [63:0] k);
        logic [27:0] c, d;
        logic [55:0] cd;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-pc1_t[i]];
            d[27-i] = k[64-pc1_t[28+i]];
        end
        exp_par = 1'b0;
        for (int b = 0; b < 8; b++)
            if ($countones(k[8*b +: 8]) % 2 == 0) exp_par = 1'b1;
        for (int r = 0; r < 16; r++) begin
            c  = rotl28(c, shifts[r]);
            d  = rotl28(d, shifts[r]);
            cd = {c, d};
            for (int j = 0; j < 48; j++) exp_keys[r][47-j] = cd[56-pc2_t[j]];
        end
    endtask

    // Runs one full schedule from a negedge; optional stall and ignored-start glitch.
    task automatic drive_schedule(input logic [63:0] k, input bit dec, input int stall_at,
                                  input int stall_len, input int glitch_at, input bit chain);
        int          idx = 0;
        int          stalled = 0;
        int          budget = 0;
        logic [47:0] exp;
        build_model(k);
        ks_if.key     = k;
        ks_if.decrypt = dec;
        ks_if.start   = 1'b1;
        ks_if.advance = 1'b1;
        @(negedge clk);
        ks_if.start = 1'b0;
        checks++;
        if (ks_if.parity_err !== (par_en && exp_par)) begin
            errors++;
            $display("FAIL parity_err key=%h: got %b expected %b", k, ks_if.parity_err, par_en && exp_par);
        end
        while (idx < 16 && budget < 100) begin
            exp = dec ? exp_keys[15-idx] : exp_keys[idx];
            checks++;
            if (ks_if.subkey !== exp) begin
                errors++;
                $display("FAIL subkey pos %0d dec=%0d: got %h expected %h", idx, dec, ks_if.subkey, exp);
            end
            checks++;
            if ({ks_if.subkey_valid, ks_if.round, ks_if.busy, ks_if.done} !== {1'b1, idx[3:0], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL status pos %0d: got valid/round/busy/done %b expected %b", idx,
                         {ks_if.subkey_valid, ks_if.round, ks_if.busy, ks_if.done}, {1'b1, idx[3:0], 1'b1, 1'b0});
            end
            if (idx == 0)  obs_first  = ks_if.subkey;
            if (idx == 1)  obs_second = ks_if.subkey;
            if (idx == 15) obs_last   = ks_if.subkey;
            ks_if.start = (idx == glitch_at);
            if (idx == glitch_at) begin
                ks_if.key     = ~k;
                ks_if.decrypt = ~dec;
            end
            if (idx == stall_at && stalled < stall_len) begin
                ks_if.advance = 1'b0;
                stalled++;
            end else begin
                ks_if.advance = 1'b1;
                idx++;
            end
            @(negedge clk);
            budget++;
        end
        ks_if.start   = 1'b0;
        ks_if.advance = 1'b0;
        checks++;
        if (idx != 16) begin
            errors++;
            $display("FAIL schedule timeout: reached pos %0d required 16", idx);
        end
        exp = dec ? exp_keys[0] : exp_keys[15];
        checks++;
        if ({ks_if.subkey_valid, ks_if.round, ks_if.busy, ks_if.done, ks_if.subkey} !== {7'b0_0000_01, exp}) begin
            errors++;
            $display("FAIL done cycle: got status %b subkey %h expected status 0000001 subkey %h",
                     {ks_if.subkey_valid, ks_if.round, ks_if.busy, ks_if.done}, ks_if.subkey, exp);
        end
        if (!chain) begin
            @(negedge clk);
            checks++;
            if ({ks_if.subkey_valid, ks_if.round, ks_if.busy, ks_if.done} !== 7'b0) begin
                errors++;
                $display("FAIL after done: got status %b expected 0000000",
                         {ks_if.subkey_valid, ks_if.round, ks_if.busy, ks_if.done});
            end
        end
    endtask

    task automatic test_reset();
        ks_if.start = 1'b0; ks_if.advance = 1'b0; ks_if.decrypt = 1'b0; ks_if.key = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ks_if.subkey, ks_if.subkey_valid, ks_if.round, ks_if.busy, ks_if.done, ks_if.parity_err} !== '0) begin
            errors++;
            $display("FAIL reset state: got subkey %h status %b expected all zero", ks_if.subkey,
                     {ks_if.subkey_valid, ks_if.round, ks_if.busy, ks_if.done, ks_if.parity_err});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_advance();
        ks_if.advance = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({ks_if.subkey_valid, ks_if.round, ks_if.busy, ks_if.done} !== 7'b0) begin
                errors++;
                $display("FAIL idle advance: got status %b expected 0000000",
                         {ks_if.subkey_valid, ks_if.round, ks_if.busy, ks_if.done});
            end
        end
        ks_if.advance = 1'b0;
    endtask

    task automatic test_known_vectors();
        drive_schedule(kat_key, 1'b0, -1, 0, -1, 1'b0);
        checks++;
        if ({obs_first, obs_second, obs_last} !== {kat_k1, kat_k2, kat_k16}) begin
            errors++;
            $display("FAIL encrypt vectors: got %h %h %h expected %h %h %h",
                     obs_first, obs_second, obs_last, kat_k1, kat_k2, kat_k16);
        end
        drive_schedule(kat_key, 1'b1, -1, 0, -1, 1'b0);
        checks++;
        if ({obs_first, obs_last} !== {kat_k16, kat_k1}) begin
            errors++;
            $display("FAIL decrypt vectors: got %h %h expected %h %h", obs_first, obs_last, kat_k16, kat_k1);
        end
    endtask

    task automatic test_stall();
        drive_schedule(kat_key, 1'b0, 3, 5, -1, 1'b0);
        drive_schedule({$urandom, $urandom}, 1'b1, 9, 3, -1, 1'b0);
    endtask

    task automatic test_start_ignored();
        drive_schedule({$urandom, $urandom}, 1'b0, -1, 0, 4, 1'b0);
        drive_schedule({$urandom, $urandom}, 1'b1, 4, 2, 4, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive_schedule({$urandom, $urandom}, 1'b0, -1, 0, -1, 1'b1);
        drive_schedule({$urandom, $urandom}, 1'b1, -1, 0, -1, 1'b0);
    endtask

    task automatic test_zero_key();
        drive_schedule(64'h0, 1'b0, -1, 0, -1, 1'b0);
        drive_schedule(64'h0, 1'b1, -1, 0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_round();
        int budget = 0;
        ks_if.key = kat_key; ks_if.decrypt = 1'b0; ks_if.start = 1'b1; ks_if.advance = 1'b1;
        @(negedge clk);
        ks_if.start = 1'b0;
        while (ks_if.round != 4'd7 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (ks_if.round !== 4'd7) begin
            errors++;
            $display("FAIL reach round 7: got %0d required 7", ks_if.round);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ks_if.subkey, ks_if.subkey_valid, ks_if.round, ks_if.busy, ks_if.done, ks_if.parity_err} !== '0) begin
            errors++;
            $display("FAIL async reset: got subkey %h status %b expected all zero", ks_if.subkey,
                     {ks_if.subkey_valid, ks_if.round, ks_if.busy, ks_if.done, ks_if.parity_err});
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({ks_if.subkey_valid, ks_if.busy, ks_if.done} !== 3'b0) begin
                errors++;
                $display("FAIL held reset: got valid/busy/done %b expected 000",
                         {ks_if.subkey_valid, ks_if.busy, ks_if.done});
            end
        end
        rst = 1'b0;
        ks_if.advance = 1'b0;
        @(negedge clk);
        drive_schedule(kat_key, 1'b0, -1, 0, -1, 1'b0);
        checks++;
        if (obs_first !== kat_k1) begin
            errors++;
            $display("FAIL K1 after reset: got %h expected %h", obs_first, kat_k1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++)
            drive_schedule({$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                           $urandom_range(0, 3), $urandom_range(0, 15), 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle_advance();
        test_known_vectors();
        test_stall();
        test_start_ignored();
        test_back_to_back();
        test_zero_key();
        test_reset_mid_round();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
